lzrw1_decompressor_core: RTL and testbench
==========================================

# lzrw1_decompressor_core

Parametrised LZRW1 decompression engine, successor to `decompressor_top`. It consumes 16-bit compressed items, each tagged with one control bit, and emits the decompressed byte stream through a valid/ready interface with full backpressure. History depth and the offset/length split are configurable. Invalid back-references raise a sticky error. It sits between the compressed-item source and the byte sink, replacing the busy-flag handshake with valid/ready.

## Interface
- `HISTORY_SIZE`, default 4096: history RAM depth in bytes; must be a power of 2 and at least 16.
- `OFFSET_WIDTH`, default $clog2(HISTORY_SIZE): width of the copy offset field; 16-OFFSET_WIDTH must be ≥ 2.
- `MIN_MATCH`, default 3: copy length = length field + MIN_MATCH.
- `COUNT_WIDTH`, default 32: width of the output byte counter.

Ports (name, direction, width, meaning):
- `clock` in 1: clock, rising-edge.
- `reset` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous soft reset; same effect as reset, excluding RAM contents.
- `in_valid` in 1: input item valid.
- `in_ready` out 1: core accepts the item this cycle.
- `in_data` in 16: compressed item.
- `in_ctrl` in 1: 0 = literal, 1 = copy.
- `out_valid` out 1: out_byte valid.
- `out_ready` in 1: sink accepts out_byte.
- `out_byte` out 8: decompressed byte.
- `busy` out 1: a copy is in progress or an output byte is pending.
- `error` out 1: sticky invalid-reference flag.
- `byte_count` out COUNT_WIDTH: total bytes handed off (out_valid && out_ready); wraps modulo 2^COUNT_WIDTH.

## Operation
- **Literal item** (`in_ctrl`=0): the byte is `in_data[7:0]`; `in_data[15:8]` is ignored. The byte is written to history and loaded into the output register.
- **Copy item** (`in_ctrl`=1):
  - offset = `in_data[OFFSET_WIDTH-1:0]`.
  - length = `in_data[15:OFFSET_WIDTH]` + MIN_MATCH.
  - Copy source address = wr_ptr − offset, modulo HISTORY_SIZE.
  - Each copied byte is also written back to history, so overlapping copies (offset < length) replicate correctly.
- **History** is a circular buffer of HISTORY_SIZE bytes with a 1-cycle synchronous read.
  - wr_ptr increments per byte and wraps to 0.
  - A read of the address being written in the same cycle must return the new byte (bypass). This is required for offset=1.
- **valid_hist** is a saturating count of bytes written, capped at HISTORY_SIZE.
- **Error**: a copy with offset = 0 or offset > valid_hist is rejected.
  - The item is consumed, nothing is emitted, `error` is set, and the core enters ERROR.
- **States:**
  - IDLE: accepts literal or copy. A valid copy goes to COPY_RD; an invalid copy goes to ERROR.
  - COPY_RD: issues the first read (1 cycle), then goes to COPY.
  - COPY: emits one byte per cycle in which the output register is free or drained; stalls otherwise. After the last byte it returns to IDLE.
  - ERROR: `in_ready`=0 and `out_valid`=0. Exits only via reset or `clear`.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready) && !error.
- `busy` = (state != IDLE) || out_valid.
- **Reset / clear outputs:**
  - `out_valid`=0, `out_byte`=0, `error`=0, `byte_count`=0, wr_ptr=0, valid_hist=0, state=IDLE.
  - `in_ready` is 0 while `reset` is low.
- **Reset mid-copy:** the remaining copy bytes are discarded and no partial byte is emitted afterwards.
- **`clear` and `in_valid` high in the same cycle:** `clear` wins and the item is not accepted.

## Timing
- **Literal:** accepted at edge k, so `out_valid`=1 with the byte after edge k. A back-to-back literal can be accepted at edge k+1 if `out_ready`=1, giving 1 byte/cycle.
- **Copy of length L**, accepted at edge k with `out_ready` held at 1:
  - First byte is valid after edge k+2.
  - Byte i is valid after edge k+2+i.
  - `in_ready` returns high in the cycle the last byte is presented.
  - Occupancy is L+1 cycles.
- **Backpressure:** while `out_valid` && !`out_ready`, `out_byte` and `out_valid` hold stable, and the pipeline and read pointer freeze.
- **Counter:** `byte_count` updates on the edge of each handshake.
- **Error:** `error` rises the cycle after the offending item is accepted.

## Test plan
- **Literals then copy:** literals 0x61, 0x62, 0x63, then copy 0x0003 (offset 3, length 3), `out_ready`=1 → a b c a b c; `byte_count`=6; the first copy byte appears 2 cycles after acceptance.
- **Overlap:** literal 0x78, then copy 0x2001 (offset 1, length 5) → 0x78 six times; exercises the bypass path.
- **Backpressure:** drive `out_ready` with the pattern 1,0,0,1,0,1… during an 18-byte copy (field 0xF) → output is identical, no byte is dropped or duplicated, and `out_byte` is stable while stalled.
- **Wrap:** with HISTORY_SIZE=256 and OFFSET_WIDTH=8, write 300 literals (i mod 256), then copy offset 200 length 3 → bytes 100, 101, 102; a copy with offset 0 → `error`=1 and `in_ready`=0 until `clear`.
- **Invalid reference:** after 2 literals, copy offset 5 → `error`=1, nothing emitted, `byte_count`=2.
- **Reset mid-copy:** assert `reset` during the 3rd byte of a length-10 copy → all outputs return to reset values immediately; after release, a fresh literal 0x41 is emitted as the first byte.

Source files
------------

// File: rtl/lzrw1_decompressor_core.sv
// LZRW1 decompression engine.
// Takes 16-bit literal/copy items and produces a byte stream on a
// valid/ready output. Back-references are resolved against a circular
// history RAM. A bad reference parks the core in ERROR until reset or clear.
module lzrw1_decompressor_core #(
  parameter int HISTORY_SIZE = 4096,
  parameter int OFFSET_WIDTH = $clog2(HISTORY_SIZE),
  parameter int MIN_MATCH    = 3,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_data,
  input  logic                   in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   busy,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  localparam int AW = $clog2(HISTORY_SIZE);
  localparam int LW = 16 - OFFSET_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_COPY_RD, S_COPY, S_ERROR} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [7:0]             r_mem [HISTORY_SIZE];
  logic [7:0]             r_rdData;
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW:0]            r_validHist;
  logic [16:0]            r_remain;
  logic                   r_outValid;
  logic [7:0]             r_outByte;
  logic                   r_error;
  logic [COUNT_WIDTH-1:0] r_byteCount;

  logic                    w_drained;
  logic [OFFSET_WIDTH-1:0] w_offset;
  logic [LW-1:0]           w_lenField;
  logic [16:0]             w_copyLen;
  logic                    w_badRef;
  logic [AW-1:0]           w_srcAddr;
  logic                    w_accept;
  logic                    w_acceptLit;
  logic                    w_acceptCopy;
  logic                    w_acceptBad;
  logic                    w_copyLoad;
  logic                    w_rdEn;
  logic                    w_wrEn;
  logic [7:0]              w_wrData;

  assign w_drained    = !r_outValid || out_ready;
  assign w_offset     = in_data[OFFSET_WIDTH-1:0];
  assign w_lenField   = in_data[15:OFFSET_WIDTH];
  assign w_copyLen    = 17'(w_lenField) + 17'(MIN_MATCH);
  assign w_badRef     = (w_offset == '0) || (32'(w_offset) > 32'(r_validHist));
  // The history depth is a power of two, so truncating the difference wraps it.
  assign w_srcAddr    = AW'(32'(r_wrPtr) - 32'(w_offset));

  assign in_ready     = reset && (r_state == S_IDLE) && w_drained && !r_error;
  assign w_accept     = in_valid && in_ready && !clear;
  assign w_acceptLit  = w_accept && !in_ctrl;
  assign w_acceptCopy = w_accept && in_ctrl && !w_badRef;
  assign w_acceptBad  = w_accept && in_ctrl && w_badRef;

  // A copy byte moves into the output register only when that register is free.
  assign w_copyLoad   = (r_state == S_COPY) && w_drained && !clear;
  assign w_rdEn       = !clear && ((r_state == S_COPY_RD) || w_copyLoad);
  assign w_wrEn       = w_acceptLit || w_copyLoad;
  assign w_wrData     = w_acceptLit ? in_data[7:0] : r_rdData;

  assign out_valid    = r_outValid;
  assign out_byte     = r_outByte;
  assign error        = r_error;
  assign byte_count   = r_byteCount;
  assign busy         = (r_state != S_IDLE) || r_outValid;

  // History RAM: synchronous read, with the byte written this cycle forwarded to the reader.
  always_ff @(posedge clock) begin
    if (w_wrEn) r_mem[r_wrPtr] <= w_wrData;
    if (w_rdEn) r_rdData <= (w_wrEn && (r_wrPtr == r_rdPtr)) ? w_wrData : r_mem[r_rdPtr];
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic: clear always returns to IDLE, and ERROR is left only that way.
  always_comb begin
    w_nextState = r_state;
    if (clear) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acceptCopy)     w_nextState = S_COPY_RD;
          else if (w_acceptBad) w_nextState = S_ERROR;
        end
        S_COPY_RD: w_nextState = S_COPY;
        S_COPY: begin
          if (w_copyLoad && (r_remain == 17'd1)) w_nextState = S_IDLE;
        end
        default: w_nextState = r_state;
      endcase
    end
  end

  // Datapath: pointers, copy length, output register, byte counter and error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_validHist <= '0;
      r_remain    <= '0;
      r_outValid  <= 1'b0;
      r_outByte   <= '0;
      r_error     <= 1'b0;
      r_byteCount <= '0;
    end else if (clear) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_validHist <= '0;
      r_remain    <= '0;
      r_outValid  <= 1'b0;
      r_outByte   <= '0;
      r_error     <= 1'b0;
      r_byteCount <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + AW'(1);
        if (r_validHist != (AW+1)'(HISTORY_SIZE)) r_validHist <= r_validHist + (AW+1)'(1);
      end
      if (w_acceptCopy) begin
        r_rdPtr  <= w_srcAddr;
        r_remain <= w_copyLen;
      end else begin
        if (w_rdEn)     r_rdPtr  <= r_rdPtr + AW'(1);
        if (w_copyLoad) r_remain <= r_remain - 17'd1;
      end
      if (w_acceptLit) begin
        r_outValid <= 1'b1;
        r_outByte  <= in_data[7:0];
      end else if (w_copyLoad) begin
        r_outValid <= 1'b1;
        r_outByte  <= r_rdData;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
      if (r_outValid && out_ready) r_byteCount <= r_byteCount + COUNT_WIDTH'(1);
      if (w_acceptBad) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lzrw1_decompressor_core.sv
// Directed testbench for lzrw1_decompressor_core.
// Instance A uses the default geometry; instance B uses a 256-byte history for the wrap test.
// 'sel' routes the shared stimulus to one instance and muxes its outputs back.
module tb_lzrw1_decompressor_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        inValid = 1'b0;
  logic        inCtrl = 1'b0;
  logic [15:0] inData = '0;
  logic        outReady = 1'b1;
  logic        sel = 1'b0;

  logic        aInValid, aInReady, aOutValid, aBusy, aError;
  logic [7:0]  aOutByte;
  logic [31:0] aByteCount;
  logic        bInValid, bInReady, bOutValid, bBusy, bError;
  logic [7:0]  bOutByte;
  logic [31:0] bByteCount;

  logic        inReady, outValid, busy, error;
  logic [7:0]  outByte;
  logic [31:0] byteCount;

  int compared = 0;
  int mismatched = 0;
  int cycles = 0;
  logic [7:0] outQ [$];

  assign aInValid  = inValid && !sel;
  assign bInValid  = inValid && sel;
  assign inReady   = sel ? bInReady : aInReady;
  assign outValid  = sel ? bOutValid : aOutValid;
  assign outByte   = sel ? bOutByte : aOutByte;
  assign busy      = sel ? bBusy : aBusy;
  assign error     = sel ? bError : aError;
  assign byteCount = sel ? bByteCount : aByteCount;

  lzrw1_decompressor_core dutA (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(aOutValid), .out_ready(outReady), .out_byte(aOutByte),
    .busy(aBusy), .error(aError), .byte_count(aByteCount)
  );

  lzrw1_decompressor_core #(.HISTORY_SIZE(256), .OFFSET_WIDTH(8)) dutB (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(bOutValid), .out_ready(outReady), .out_byte(bOutByte),
    .busy(bBusy), .error(bError), .byte_count(bByteCount)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycles++;

  // Record every byte that will be handed off at the coming rising edge.
  always @(negedge clock) begin
    if (reset && outValid && outReady) outQ.push_back(outByte);
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one item and hold it until the selected core accepts it.
  task automatic sendItem(input logic c, input logic [15:0] d);
    int n = 0;
    inCtrl = c;
    inData = d;
    inValid = 1'b1;
    while (!inReady && n < 100) begin
      tick();
      n++;
    end
    if (!inReady) begin
      compared++; mismatched++;
      $display("[TB] FAIL send_timeout: in_ready=%b required 1", inReady);
    end
    tick();
    inValid = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) begin
      compared++; mismatched++;
      $display("[TB] FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 0", inReady); end
    compared++; if (bInReady !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready_b: got %b want 0", bInReady); end
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", outValid); end
    compared++; if (outByte !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out_byte: got %h want 00", outByte); end
    compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_error: got %b want 0", error); end
    compared++; if (byteCount !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", byteCount); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    tick();
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", inReady); end
  endtask

  task automatic test_literals_copy();
    logic [7:0] expBytes [6] = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
    sel = 1'b0;
    outReady = 1'b1;
    outQ.delete();
    sendItem(1'b0, 16'h0061);
    sendItem(1'b0, 16'h0062);
    sendItem(1'b0, 16'h0063);
    sendItem(1'b1, 16'h0003);
    tick();
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL copy_latency_k1: out_valid=%b want 0", outValid); end
    tick();
    compared++; if (outValid !== 1'b1 || outByte !== 8'h61) begin mismatched++; $display("[TB] FAIL copy_latency_k2: valid=%b byte=%h want 1/61", outValid, outByte); end
    waitDone();
    compared++; if (outQ.size() != 6) begin mismatched++; $display("[TB] FAIL abc_len: got %0d want 6", outQ.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < outQ.size()) begin
        compared++; if (outQ[i] !== expBytes[i]) begin mismatched++; $display("[TB] FAIL abc_byte%0d: got %h want %h", i, outQ[i], expBytes[i]); end
      end
    end
    compared++; if (byteCount !== 32'd6) begin mismatched++; $display("[TB] FAIL abc_count: got %0d want 6", byteCount); end
  endtask

  task automatic test_overlap();
    outQ.delete();
    sendItem(1'b0, 16'h0078);
    sendItem(1'b1, 16'h2001);
    waitDone();
    compared++; if (outQ.size() != 6) begin mismatched++; $display("[TB] FAIL overlap_len: got %0d want 6", outQ.size()); end
    for (int i = 0; i < outQ.size(); i++) begin
      compared++; if (outQ[i] !== 8'h78) begin mismatched++; $display("[TB] FAIL overlap_byte%0d: got %h want 78", i, outQ[i]); end
    end
    compared++; if (byteCount !== 32'd12) begin mismatched++; $display("[TB] FAIL overlap_count: got %0d want 12", byteCount); end
  endtask

  task automatic test_backpressure();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic prevStall = 1'b0;
    logic [7:0] prevByte = '0;
    int c = 0;
    outQ.delete();
    for (int i = 0; i < 4; i++) sendItem(1'b0, 16'(8'h10 + i));
    waitDone();
    outQ.delete();
    sendItem(1'b1, 16'hF004);
    while (outQ.size() < 18 && c < 300) begin
      if (prevStall) begin
        compared++;
        if (outValid !== 1'b1 || outByte !== prevByte) begin
          mismatched++;
          $display("[TB] FAIL stall_hold: valid=%b byte=%h want 1/%h", outValid, outByte, prevByte);
        end
      end
      outReady = pat[c % 6];
      prevStall = outValid && !outReady;
      prevByte = outByte;
      tick();
      c++;
    end
    outReady = 1'b1;
    waitDone();
    compared++; if (outQ.size() != 18) begin mismatched++; $display("[TB] FAIL bp_len: got %0d want 18", outQ.size()); end
    for (int i = 0; i < outQ.size(); i++) begin
      compared++; if (outQ[i] !== 8'(8'h10 + (i % 4))) begin mismatched++; $display("[TB] FAIL bp_byte%0d: got %h want %h", i, outQ[i], 8'(8'h10 + (i % 4))); end
    end
    compared++; if (byteCount !== 32'd34) begin mismatched++; $display("[TB] FAIL bp_count: got %0d want 34", byteCount); end
  endtask

  task automatic test_back_to_back();
    int start;
    outQ.delete();
    start = cycles;
    for (int i = 0; i < 4; i++) sendItem(1'b0, 16'(8'hA0 + i));
    compared++; if (cycles - start != 4) begin mismatched++; $display("[TB] FAIL b2b_cycles: got %0d want 4", cycles - start); end
    waitDone();
    compared++; if (outQ.size() != 4) begin mismatched++; $display("[TB] FAIL b2b_len: got %0d want 4", outQ.size()); end
    compared++; if (byteCount !== 32'd38) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d want 38", byteCount); end
  endtask

  task automatic test_invalid_ref();
    clear = 1'b1;
    inValid = 1'b1;
    inCtrl = 1'b0;
    inData = 16'h0055;
    tick();
    clear = 1'b0;
    inValid = 1'b0;
    compared++; if (byteCount !== 32'd0) begin mismatched++; $display("[TB] FAIL clear_count: got %0d want 0", byteCount); end
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_wins: out_valid=%b want 0", outValid); end
    outQ.delete();
    sendItem(1'b0, 16'h0001);
    sendItem(1'b0, 16'h0002);
    sendItem(1'b1, 16'h0005);
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL badref_error: got %b want 1", error); end
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL badref_in_ready: got %b want 0", inReady); end
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL badref_out_valid: got %b want 0", outValid); end
    inValid = 1'b1;
    inCtrl = 1'b0;
    inData = 16'h0033;
    for (int i = 0; i < 4; i++) tick();
    compared++; if (inReady !== 1'b0 || error !== 1'b1) begin mismatched++; $display("[TB] FAIL badref_sticky: in_ready=%b error=%b want 0/1", inReady, error); end
    inValid = 1'b0;
    compared++; if (outQ.size() != 2) begin mismatched++; $display("[TB] FAIL badref_len: got %0d want 2", outQ.size()); end
    compared++; if (byteCount !== 32'd2) begin mismatched++; $display("[TB] FAIL badref_count: got %0d want 2", byteCount); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    compared++; if (error !== 1'b0 || inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL badref_clear: error=%b in_ready=%b want 0/1", error, inReady); end
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    outReady = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    outQ.delete();
    for (int i = 0; i < 300; i++) sendItem(1'b0, 16'(i % 256));
    waitDone();
    compared++; if (byteCount !== 32'd300) begin mismatched++; $display("[TB] FAIL wrap_lit_count: got %0d want 300", byteCount); end
    outQ.delete();
    sendItem(1'b1, 16'h00C8);
    waitDone();
    compared++; if (outQ.size() != 3) begin mismatched++; $display("[TB] FAIL wrap_len: got %0d want 3", outQ.size()); end
    for (int i = 0; i < outQ.size(); i++) begin
      compared++; if (outQ[i] !== 8'(100 + i)) begin mismatched++; $display("[TB] FAIL wrap_byte%0d: got %0d want %0d", i, outQ[i], 100 + i); end
    end
    compared++; if (byteCount !== 32'd303) begin mismatched++; $display("[TB] FAIL wrap_count: got %0d want 303", byteCount); end
    sendItem(1'b1, 16'h0000);
    compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_off_error: got %b want 1", error); end
    tick();
    tick();
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_off_in_ready: got %b want 0", inReady); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    compared++; if (error !== 1'b0 || inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_off_clear: error=%b in_ready=%b want 0/1", error, inReady); end
    sel = 1'b0;
  endtask

  task automatic test_reset_midcopy();
    sel = 1'b0;
    outReady = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sendItem(1'b0, 16'h0070);
    sendItem(1'b0, 16'h0071);
    sendItem(1'b1, 16'h7002);
    for (int i = 0; i < 4; i++) tick();
    compared++; if (outValid !== 1'b1 || outByte !== 8'h70) begin mismatched++; $display("[TB] FAIL midcopy_third: valid=%b byte=%h want 1/70", outValid, outByte); end
    reset = 1'b0;
    #1;
    compared++; if (outValid !== 1'b0 || outByte !== 8'h00) begin mismatched++; $display("[TB] FAIL midcopy_reset_out: valid=%b byte=%h want 0/00", outValid, outByte); end
    compared++; if (busy !== 1'b0 || inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL midcopy_reset_ctl: busy=%b in_ready=%b want 0/0", busy, inReady); end
    compared++; if (byteCount !== 32'd0 || error !== 1'b0) begin mismatched++; $display("[TB] FAIL midcopy_reset_cnt: count=%0d error=%b want 0/0", byteCount, error); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    outQ.delete();
    sendItem(1'b0, 16'h0041);
    waitDone();
    for (int i = 0; i < 4; i++) tick();
    compared++; if (outQ.size() != 1) begin mismatched++; $display("[TB] FAIL midcopy_after_len: got %0d want 1", outQ.size()); end
    if (outQ.size() > 0) begin
      compared++; if (outQ[0] !== 8'h41) begin mismatched++; $display("[TB] FAIL midcopy_after_byte: got %h want 41", outQ[0]); end
    end
    compared++; if (byteCount !== 32'd1) begin mismatched++; $display("[TB] FAIL midcopy_after_count: got %0d want 1", byteCount); end
  endtask

  initial begin
    test_reset();
    test_literals_copy();
    test_overlap();
    test_backpressure();
    test_back_to_back();
    test_invalid_ref();
    test_wrap();
    test_reset_midcopy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
